// File: rtl/cam_pipe_seq_pkg.sv
// Shared types for the camera pipeline bring-up sequencer.
package top_pkg;

   // Sequencer states, exported on the 3-bit state port.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PWRUP    = 3'd1,
      CFG      = 3'd2,
      CFG_WAIT = 3'd3,
      SYNC     = 3'd4,
      RUN      = 3'd5,
      FAULT    = 3'd6
   } seq_state_t;

   // Reason for the most recent FAULT entry.
   typedef enum logic [1:0] {
      FLT_NONE = 2'd0,
      FLT_I2C  = 2'd1,
      FLT_LOCK = 2'd2,
      FLT_WDOG = 2'd3
   } fault_t;

   // Largest of three cycle counts; sizes the shared state timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cam_pipe_seq_frame_meter.sv
// Frame meter: edge detection on the synchronized CSI frame/line levels,
// per-frame line counting and a good/bad verdict pulse at every frame end.
module frame_meter #(
   parameter int LINES_PER_FRAME = 480
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic csi_in_frame_i,
   input  logic csi_in_line_i,
   output logic frame_start_o,
   output logic frame_good_o,
   output logic frame_bad_o
);

   // One value beyond LINES_PER_FRAME is needed so an over-long frame
   // saturates above the target instead of landing on it.
   localparam int LW = $clog2(LINES_PER_FRAME + 2);
   localparam logic [LW-1:0] LINES_TGT = LW'(LINES_PER_FRAME);

   logic [1:0]    in_vec;
   logic [1:0]    prev_vec;
   logic [1:0]    rise_vec;
   logic          frame_fall;
   logic          line_rise;
   logic [LW-1:0] line_cnt_q;
   logic [LW-1:0] line_cnt_d;

   // bit 0 = frame level, bit 1 = line level
   assign in_vec = {csi_in_line_i, csi_in_frame_i};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_edge
      logic prev_q;

      // One-cycle registered copy of each input level for edge detection.
      always_ff @(posedge clk) begin
         if (reset) begin
            prev_q <= 1'b0;
         end else begin
            prev_q <= in_vec[gi];
         end
      end

      assign prev_vec[gi] = prev_q;
      assign rise_vec[gi] = in_vec[gi] & ~prev_q;
   end

   assign frame_fall = ~in_vec[0] & prev_vec[0];
   // Only line edges while the frame is active are counted.
   assign line_rise  = rise_vec[1] & in_vec[0];

   // Line counter: restarts at each frame start, saturates one past target.
   always_comb begin
      line_cnt_d = line_cnt_q;
      if (clear_i) begin
         line_cnt_d = '0;
      end else if (rise_vec[0]) begin
         line_cnt_d = line_rise ? LW'(1) : '0;
      end else if (line_rise && (line_cnt_q <= LINES_TGT)) begin
         line_cnt_d = line_cnt_q + LW'(1);
      end
   end

   // Line counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         line_cnt_q <= '0;
      end else begin
         line_cnt_q <= line_cnt_d;
      end
   end

   assign frame_start_o = rise_vec[0];
   assign frame_good_o  = frame_fall & (line_cnt_q == LINES_TGT);
   assign frame_bad_o   = frame_fall & (line_cnt_q != LINES_TGT);

endmodule

// File: rtl/cam_pipe_seq.sv
// Camera pipeline sequencer: camera power-up, I2C configuration with
// retries, stream lock before releasing the datapath, and a frame watchdog
// in RUN that tears everything down and restarts on stream loss.
module cam_pipe_seq
   import top_pkg::*;
#(
   parameter int PWRUP_CYC       = 1_000_000,
   parameter int I2C_TRIES       = 3,
   parameter int I2C_TMO_CYC     = 50_000_000,
   parameter int LINES_PER_FRAME = 480,
   parameter int LOCK_FRAMES     = 4,
   parameter int WDOG_CYC        = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_done,
   input  logic       i2c_err,
   input  logic       csi_in_frame,
   input  logic       csi_in_line,
   output logic       cam_en,
   output logic       i2c_start,
   output logic       pipe_reset,
   output logic       hdmi_en,
   output logic [2:0] state,
   output logic [1:0] fault_code,
   output logic [7:0] restart_cnt
);

   localparam int TMR_W  = $clog2(max3(PWRUP_CYC, I2C_TMO_CYC, WDOG_CYC) + 1);
   localparam int TRY_W  = $clog2(I2C_TRIES + 1);
   localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

   localparam logic [TMR_W-1:0]  PWRUP_LAST = TMR_W'(PWRUP_CYC - 1);
   localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(I2C_TMO_CYC - 1);
   localparam logic [TMR_W-1:0]  WDOG_LAST  = TMR_W'(WDOG_CYC - 1);
   localparam logic [TRY_W-1:0]  TRIES_MAX  = TRY_W'(I2C_TRIES);
   localparam logic [GOOD_W-1:0] LOCK_TGT   = GOOD_W'(LOCK_FRAMES);

   seq_state_t        state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [GOOD_W-1:0] good_q, good_d, good_upd;
   fault_t            fault_q, fault_d, fault_new;
   logic [7:0]        restart_q, restart_d;
   logic              cam_en_q, cam_en_d;
   logic              i2c_start_q, i2c_start_d;

   logic frame_start, frame_good, frame_bad;
   logic enter_pwrup, enter_fault;
   logic cfg_fail, wdog_hit;

   assign enter_pwrup = (state_d == PWRUP) && (state_q != PWRUP);
   assign enter_fault = (state_d == FAULT) && (state_q != FAULT);

   frame_meter #(
      .LINES_PER_FRAME (LINES_PER_FRAME)
   ) u_meter (
      .clk            (clk),
      .reset          (reset),
      .clear_i        (enter_pwrup),
      .csi_in_frame_i (csi_in_frame),
      .csi_in_line_i  (csi_in_line),
      .frame_start_o  (frame_start),
      .frame_good_o   (frame_good),
      .frame_bad_o    (frame_bad)
   );

   // An error beats a simultaneous done; a done beats a simultaneous timeout.
   assign cfg_fail = i2c_err || (!i2c_done && (timer_q >= TMO_LAST));
   // A frame start in the expiry cycle still counts as in time.
   assign wdog_hit = !frame_start && (timer_q >= WDOG_LAST);

   // Good-frame tally as seen while hunting for lock; frozen elsewhere.
   always_comb begin
      good_upd = good_q;
      if (state_q == SYNC) begin
         if (frame_bad) begin
            good_upd = '0;
         end else if (frame_good && (good_q != LOCK_TGT)) begin
            good_upd = good_q + GOOD_W'(1);
         end
      end
   end

   // Next-state decode plus the fault reason for a FAULT entry.
   always_comb begin
      state_d   = state_q;
      fault_new = FLT_NONE;
      unique case (state_q)
         IDLE: begin
            state_d = PWRUP;
         end
         PWRUP: begin
            if (timer_q >= PWRUP_LAST) begin
               state_d = CFG;
            end
         end
         CFG: begin
            state_d = CFG_WAIT;
         end
         CFG_WAIT: begin
            if (cfg_fail) begin
               if (tries_q < TRIES_MAX) begin
                  state_d = CFG;
               end else begin
                  state_d   = FAULT;
                  fault_new = FLT_I2C;
               end
            end else if (i2c_done) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (good_upd == LOCK_TGT) begin
               state_d = RUN;
            end else if (wdog_hit) begin
               state_d   = FAULT;
               fault_new = FLT_LOCK;
            end
         end
         RUN: begin
            if (wdog_hit) begin
               state_d   = FAULT;
               fault_new = FLT_WDOG;
            end
         end
         FAULT: begin
            if (timer_q >= PWRUP_LAST) begin
               state_d = PWRUP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shared state timer: restarts on every state change except SYNC->RUN,
   // so the frame-gap watchdog carries straight across into RUN.
   always_comb begin
      timer_d = timer_q;
      if ((state_d != state_q) && !((state_q == SYNC) && (state_d == RUN))) begin
         timer_d = '0;
      end else if (((state_q == SYNC) || (state_q == RUN)) && frame_start) begin
         timer_d = TMR_W'(1);
      end else if (timer_q != '1) begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   // Counters, sticky fault code and registered outputs next-state.
   always_comb begin
      tries_d     = tries_q;
      good_d      = good_upd;
      fault_d     = fault_q;
      restart_d   = restart_q;
      cam_en_d    = (state_d != IDLE) && (state_d != FAULT);
      i2c_start_d = (state_q == CFG);
      if (enter_pwrup) begin
         tries_d = '0;
         good_d  = '0;
         fault_d = FLT_NONE;
      end else if ((state_q == CFG) && (tries_q != TRIES_MAX)) begin
         tries_d = tries_q + TRY_W'(1);
      end
      if (enter_fault) begin
         fault_d = fault_new;
         if (restart_q != 8'hFF) begin
            restart_d = restart_q + 8'd1;
         end
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         tries_q     <= '0;
         good_q      <= '0;
         fault_q     <= FLT_NONE;
         restart_q   <= 8'd0;
         cam_en_q    <= 1'b0;
         i2c_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         tries_q     <= tries_d;
         good_q      <= good_d;
         fault_q     <= fault_d;
         restart_q   <= restart_d;
         cam_en_q    <= cam_en_d;
         i2c_start_q <= i2c_start_d;
      end
   end

   // Datapath reset and HDMI release are decoded straight from the state.
   assign pipe_reset  = (state_q != RUN);
   assign hdmi_en     = (state_q == RUN);
   assign cam_en      = cam_en_q;
   assign i2c_start   = i2c_start_q;
   assign state       = state_q;
   assign fault_code  = fault_q;
   assign restart_cnt = restart_q;

endmodule

// File: tb/tb_cam_pipe_seq.sv
// Bench for cam_pipe_seq: expected output events (cam_en rise, i2c_start,
// RUN entry, FAULT entry) are queued with their cycle when stimulus is
// driven and checked in order as the monitor observes them.
module tb_cam_pipe_seq;
   import top_pkg::*;

   localparam int EV_CAMEN = 0;
   localparam int EV_START = 1;
   localparam int EV_RUN   = 2;
   localparam int EV_FAULT = 3;

   typedef struct {
      int kind;
      int cyc;
      int code;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i2c_done = 1'b0;
   logic       i2c_err = 1'b0;
   logic       csi_in_frame = 1'b0;
   logic       csi_in_line = 1'b0;
   logic       cam_en, i2c_start, pipe_reset, hdmi_en;
   logic [2:0] state;
   logic [1:0] fault_code;
   logic [7:0] restart_cnt;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   logic cam_prev = 1'b0;
   logic hdmi_prev = 1'b0;
   logic [2:0] state_prev = 3'd0;
   ev_t  exp_q[$];

   cam_pipe_seq #(
      .PWRUP_CYC       (8),
      .I2C_TRIES       (3),
      .I2C_TMO_CYC     (20),
      .LINES_PER_FRAME (4),
      .LOCK_FRAMES     (2),
      .WDOG_CYC        (100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i2c_done     (i2c_done),
      .i2c_err      (i2c_err),
      .csi_in_frame (csi_in_frame),
      .csi_in_line  (csi_in_line),
      .cam_en       (cam_en),
      .i2c_start    (i2c_start),
      .pipe_reset   (pipe_reset),
      .hdmi_en      (hdmi_en),
      .state        (state),
      .fault_code   (fault_code),
      .restart_cnt  (restart_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int c, input int code);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic got_ev(input int kind);
      ev_t e;
      $display("ev kind=%0d cyc=%0d code=%0d restarts=%0d", kind, cyc,
               fault_code, restart_cnt);
      if (exp_q.size() == 0) begin
         chk("unexpected_ev", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_cyc", cyc, e.cyc);
         if (kind == EV_FAULT) chk("ev_fault_code", int'(fault_code), e.code);
      end
   endtask

   // Event monitor, sampling 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (i2c_start) got_ev(EV_START);
         if (cam_en && !cam_prev) got_ev(EV_CAMEN);
         if (hdmi_en && !hdmi_prev) got_ev(EV_RUN);
         if ((state == FAULT) && (state_prev != FAULT)) got_ev(EV_FAULT);
      end
      cam_prev   <= cam_en;
      hdmi_prev  <= hdmi_en;
      state_prev <= state;
   end

   task automatic release_reset();
      int rel;
      @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      expect_ev(EV_CAMEN, rel + 1, 0);
      expect_ev(EV_START, rel + 10, 0);
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (i2c_start) begin
            s = cyc;
            break;
         end
      end
      chk("start_seen", int'(s >= 0), 1);
   endtask

   task automatic wait_state(input logic [2:0] st, input int maxc, input string tag);
      int found;
      found = 0;
      for (int n = 0; n < maxc; n++) begin
         @(posedge clk);
         #1;
         if (state == st) begin
            found = 1;
            break;
         end
      end
      chk(tag, found, 1);
   endtask

   // Pulse done or err so the DUT samples it k edges from now.
   task automatic pulse_in(input bit is_err, input int k);
      repeat (k) @(negedge clk);
      if (is_err) i2c_err = 1'b1;
      else        i2c_done = 1'b1;
      @(negedge clk);
      i2c_err  = 1'b0;
      i2c_done = 1'b0;
   endtask

   task automatic send_frame(input int nl, input bit lock, output int st, output int en);
      @(negedge clk);
      csi_in_frame = 1'b1;
      st = cyc;
      for (int i = 0; i < nl; i++) begin
         @(negedge clk);
         csi_in_line = 1'b1;
         @(negedge clk);
         csi_in_line = 1'b0;
      end
      @(negedge clk);
      if (lock) expect_ev(EV_RUN, cyc + 1, 0);
      csi_in_frame = 1'b0;
      en = cyc;
      @(negedge clk);
      $display("frame lines=%0d start=%0d end=%0d state=%0d", nl, st, en, state);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "bench time limit");
   end

   initial begin
      int s, st, en, n;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cam_en", int'(cam_en), 0);
      chk("rst_i2c_start", int'(i2c_start), 0);
      chk("rst_pipe_reset", int'(pipe_reset), 1);
      chk("rst_hdmi_en", int'(hdmi_en), 0);
      chk("rst_state", int'(state), int'(IDLE));
      chk("rst_fault", int'(fault_code), 0);
      chk("rst_restarts", int'(restart_cnt), 0);
      mon_en = 1'b1;

      // Clean bring-up
      release_reset();
      wait_start(s);
      pulse_in(1'b0, 5);
      chk("up_sync", int'(state), int'(SYNC));
      send_frame(4, 1'b0, st, en);
      send_frame(4, 1'b1, st, en);
      chk("up_run", int'(state), int'(RUN));
      chk("up_fault", int'(fault_code), 0);
      chk("up_pipe_reset", int'(pipe_reset), 0);
      chk("up_hdmi_en", int'(hdmi_en), 1);

      // Watchdog in RUN
      send_frame(4, 1'b0, st, en);
      expect_ev(EV_FAULT, st + 100, 3);
      expect_ev(EV_CAMEN, st + 108, 0);
      expect_ev(EV_START, st + 117, 0);
      wait_state(FAULT, 150, "wdog_reached");
      chk("wdog_cyc", cyc, st + 100);
      chk("wdog_code", int'(fault_code), 3);
      chk("wdog_pipe_reset", int'(pipe_reset), 1);
      chk("wdog_hdmi_en", int'(hdmi_en), 0);
      chk("wdog_restarts", int'(restart_cnt), 1);

      // I2C retry: err, err, done
      wait_start(s);
      expect_ev(EV_START, s + 4, 0);
      pulse_in(1'b1, 3);
      wait_start(s);
      expect_ev(EV_START, s + 4, 0);
      pulse_in(1'b1, 3);
      wait_start(s);
      pulse_in(1'b0, 5);
      chk("retry_sync", int'(state), int'(SYNC));
      chk("retry_fault_clr", int'(fault_code), 0);

      // Lock rejection: 4, 3, 4, 4 lines
      send_frame(4, 1'b0, st, en);
      send_frame(3, 1'b0, st, en);
      chk("rej_after_short", int'(state), int'(SYNC));
      send_frame(4, 1'b0, st, en);
      chk("rej_after_3rd", int'(state), int'(SYNC));
      send_frame(4, 1'b1, st, en);
      chk("rej_run", int'(state), int'(RUN));

      // Reset mid-run
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_state", int'(state), int'(IDLE));
      chk("mid_cam_en", int'(cam_en), 0);
      chk("mid_i2c_start", int'(i2c_start), 0);
      chk("mid_pipe_reset", int'(pipe_reset), 1);
      chk("mid_hdmi_en", int'(hdmi_en), 0);
      chk("mid_fault", int'(fault_code), 0);
      chk("mid_restarts", int'(restart_cnt), 0);
      release_reset();

      // I2C error on every try
      wait_start(s);
      expect_ev(EV_START, s + 4, 0);
      pulse_in(1'b1, 3);
      wait_start(s);
      expect_ev(EV_START, s + 4, 0);
      pulse_in(1'b1, 3);
      wait_start(s);
      expect_ev(EV_FAULT, s + 3, 1);
      expect_ev(EV_CAMEN, s + 11, 0);
      expect_ev(EV_START, s + 20, 0);
      pulse_in(1'b1, 3);
      chk("err_fault_state", int'(state), int'(FAULT));
      chk("err_fault_code", int'(fault_code), 1);
      chk("err_restarts", int'(restart_cnt), 1);
      n = 0;
      while ((cam_en == 1'b0) && (n < 30)) begin
         n++;
         @(negedge clk);
      end
      chk("err_cam_low_cycles", n, 8);
      chk("err_fault_clr", int'(fault_code), 0);
      wait_start(s);

      // I2C timeout: never answer
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      release_reset();
      wait_start(s);
      expect_ev(EV_START, s + 21, 0);
      expect_ev(EV_START, s + 42, 0);
      expect_ev(EV_FAULT, s + 62, 1);
      expect_ev(EV_CAMEN, s + 70, 0);
      expect_ev(EV_START, s + 79, 0);
      wait_state(FAULT, 100, "tmo_reached");
      chk("tmo_restarts", int'(restart_cnt), 1);
      chk("tmo_fault_code", int'(fault_code), 1);
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      chk("pending_events", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
